// File: rtl/jtag_rx_framer.sv
// jtag_rx_framer
// Receives bytes from a JTAG receive stage running on TCK, synchronizes the
// byte-complete flag into CLOCK_50, parses frames of the form
//   0xA5, LEN (1..255), LEN payload bytes, CSUM (payload sum mod 256)
// and pushes payload bytes into a show-ahead FIFO.
// Ports:
//   CLOCK_50    in   system clock, all state on the rising edge
//   RST_N       in   asynchronous active-low reset
//   rx_data     in   byte from the receive stage, stable between rx_done rises
//   rx_done     in   byte-complete flag (TCK domain), one byte per rising edge
//   out_data    out  FIFO head payload byte (0 when empty)
//   out_valid   out  FIFO non-empty
//   out_ready   in   consumer accepts head this cycle
//   frame_ok    out  one-cycle pulse: frame completed with good checksum
//   frame_err   out  one-cycle pulse: frame aborted or bad
//   err_code    out  0 zero length, 1 checksum, 2 timeout, 3 overflow (held)
//   busy        out  parser is inside a frame
//   fifo_count  out  FIFO occupancy
module jtag_rx_framer #(
  parameter int FIFO_DEPTH = 16,
  parameter int TIMEOUT    = 5_000_000
) (
  input  logic                          CLOCK_50,
  input  logic                          RST_N,
  input  logic [7:0]                    rx_data,
  input  logic                          rx_done,
  output logic [7:0]                    out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          frame_ok,
  output logic                          frame_err,
  output logic [1:0]                    err_code,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_LEN, S_PAYLOAD, S_CSUM} state_t;

  // Synchronizer, edge register and registered byte strobe.
  logic       r_sync1, r_sync2, r_sync3;
  logic [1:0] r_vcnt;
  logic       r_armed;
  logic       r_stb;

  // r_vcnt waits until r_sync2 holds a real input sample; r_armed then
  // requires rx_done to be seen low once, so a flag already high when reset
  // releases does not count as a byte.
  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
      r_vcnt  <= 2'd0;
      r_armed <= 1'b0;
      r_stb   <= 1'b0;
    end else begin
      r_sync1 <= rx_done;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
      if (r_vcnt != 2'd2) r_vcnt <= r_vcnt + 2'd1;
      if (r_vcnt == 2'd2 && !r_sync2) r_armed <= 1'b1;
      r_stb <= r_armed & r_sync2 & ~r_sync3;
    end
  end

  // Payload FIFO.
  logic [7:0]  r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0] r_count;
  state_t      r_state;
  logic        w_pop, w_full, w_push_req, w_push, w_drop;

  assign out_valid  = (r_count != '0);
  assign w_pop      = out_valid & out_ready;
  assign w_full     = (r_count == FULL_CNT);
  assign w_push_req = (r_state == S_PAYLOAD) & r_stb;
  // A simultaneous pop frees the slot, so a full FIFO still accepts the byte.
  assign w_push     = w_push_req & (~w_full | w_pop);
  assign w_drop     = w_push_req & w_full & ~w_pop;
  assign out_data   = out_valid ? r_mem[r_rptr] : 8'h00;
  assign fifo_count = r_count;

  always_ff @(posedge CLOCK_50) begin
    if (w_push) r_mem[r_wptr] <= rx_data;
  end

  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Frame parser.
  logic [TW-1:0] r_timer;
  logic [7:0]    r_sum;
  logic [7:0]    r_rem;
  logic          r_ovf;
  logic          r_ok, r_err;
  logic [1:0]    r_code;

  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= S_IDLE;
      r_timer <= '0;
      r_sum   <= 8'h00;
      r_rem   <= 8'h00;
      r_ovf   <= 1'b0;
      r_ok    <= 1'b0;
      r_err   <= 1'b0;
      r_code  <= 2'd0;
    end else begin
      r_ok  <= 1'b0;
      r_err <= 1'b0;
      if (w_drop) r_ovf <= 1'b1;
      if (r_state == S_IDLE) begin
        r_timer <= '0;
        if (r_stb && rx_data == 8'hA5) begin
          r_state <= S_LEN;
          r_ovf   <= 1'b0;
        end
      end else if (r_stb) begin
        // A byte arriving on the timeout cycle wins over the timeout.
        r_timer <= '0;
        case (r_state)
          S_LEN: begin
            if (rx_data == 8'h00) begin
              r_state <= S_IDLE;
              r_err   <= 1'b1;
              r_code  <= 2'd0;
            end else begin
              r_rem   <= rx_data;
              r_sum   <= 8'h00;
              r_state <= S_PAYLOAD;
            end
          end
          S_PAYLOAD: begin
            r_sum <= r_sum + rx_data;
            r_rem <= r_rem - 8'd1;
            if (r_rem == 8'd1) r_state <= S_CSUM;
          end
          S_CSUM: begin
            r_state <= S_IDLE;
            if (r_ovf) begin
              r_err  <= 1'b1;
              r_code <= 2'd3;
            end else if (rx_data != r_sum) begin
              r_err  <= 1'b1;
              r_code <= 2'd1;
            end else begin
              r_ok <= 1'b1;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end else if (r_timer == TMO_LAST) begin
        r_state <= S_IDLE;
        r_timer <= '0;
        r_err   <= 1'b1;
        r_code  <= 2'd2;
      end else begin
        r_timer <= r_timer + 1'b1;
      end
    end
  end

  assign frame_ok  = r_ok;
  assign frame_err = r_err;
  assign err_code  = r_code;
  assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_jtag_rx_framer.sv
// Directed testbench for jtag_rx_framer (FIFO_DEPTH=16, short TIMEOUT).
module tb_jtag_rx_framer;

  localparam int DEPTH = 16;
  localparam int TMO   = 200;

  logic       CLOCK_50 = 1'b0;
  logic       RST_N;
  logic [7:0] rx_data;
  logic       rx_done;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       frame_ok, frame_err;
  logic [1:0] err_code;
  logic       busy;
  logic [4:0] fifo_count;

  jtag_rx_framer #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
    .CLOCK_50(CLOCK_50), .RST_N(RST_N), .rx_data(rx_data), .rx_done(rx_done),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .frame_ok(frame_ok), .frame_err(frame_err), .err_code(err_code),
    .busy(busy), .fifo_count(fifo_count)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int pass_cnt = 0;
  int total    = 0;
  int ok_cnt   = 0;
  int err_cnt  = 0;
  int both_cnt = 0;
  logic [7:0] q[$];

  // Pulse counters and consumed-byte log, sampled on the falling edge.
  always @(negedge CLOCK_50) begin
    if (frame_ok) ok_cnt++;
    if (frame_err) err_cnt++;
    if (frame_ok && frame_err) both_cnt++;
    if (out_valid && out_ready) q.push_back(out_data);
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge CLOCK_50); #1;
    rx_data = b; rx_done = 1'b1;
    repeat (4) @(posedge CLOCK_50);
    #1 rx_done = 1'b0;
    repeat (4) @(posedge CLOCK_50);
    #1;
  endtask

  // Sends a byte and raises out_ready for exactly the cycle in which the
  // byte is pushed (strobe after the 3rd edge, push on the 4th).
  task automatic send_byte_pop(input logic [7:0] b);
    @(posedge CLOCK_50); #1;
    rx_data = b; rx_done = 1'b1;
    repeat (3) @(posedge CLOCK_50);
    #1 out_ready = 1'b1;
    @(posedge CLOCK_50);
    #1 out_ready = 1'b0;
    repeat (2) @(posedge CLOCK_50);
    #1 rx_done = 1'b0;
    repeat (4) @(posedge CLOCK_50);
    #1;
  endtask

  task automatic test_reset;
    RST_N = 1'b0; rx_done = 1'b0; rx_data = 8'h00; out_ready = 1'b0;
    repeat (3) @(posedge CLOCK_50);
    #1;
    total++; if (out_valid !== 1'b0) $display("FAIL rst_valid got %0b want 0", out_valid); else pass_cnt++;
    total++; if (frame_ok !== 1'b0) $display("FAIL rst_ok got %0b want 0", frame_ok); else pass_cnt++;
    total++; if (frame_err !== 1'b0) $display("FAIL rst_err got %0b want 0", frame_err); else pass_cnt++;
    total++; if (err_code !== 2'd0) $display("FAIL rst_code got %0d want 0", err_code); else pass_cnt++;
    total++; if (busy !== 1'b0) $display("FAIL rst_busy got %0b want 0", busy); else pass_cnt++;
    total++; if (fifo_count !== 5'd0) $display("FAIL rst_count got %0d want 0", fifo_count); else pass_cnt++;
    total++; if (out_data !== 8'h00) $display("FAIL rst_data got %0h want 0", out_data); else pass_cnt++;
    RST_N = 1'b1;
    repeat (5) @(posedge CLOCK_50);
    #1;
  endtask

  task automatic test_good_frame;
    int ok0, err0;
    logic [7:0] bytes [6];
    bytes = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h66};
    out_ready = 1'b1; q.delete(); ok0 = ok_cnt; err0 = err_cnt;
    for (int i = 0; i < 6; i++) send_byte(bytes[i]);
    repeat (5) @(posedge CLOCK_50); #1;
    total++; if (ok_cnt - ok0 !== 1) $display("FAIL good_ok got %0d want 1", ok_cnt - ok0); else pass_cnt++;
    total++; if (err_cnt - err0 !== 0) $display("FAIL good_err got %0d want 0", err_cnt - err0); else pass_cnt++;
    total++; if (q.size() !== 3) $display("FAIL good_nbytes got %0d want 3", q.size()); else pass_cnt++;
    if (q.size() == 3) begin
      total++; if (q[0] !== 8'h11) $display("FAIL good_b0 got %0h want 11", q[0]); else pass_cnt++;
      total++; if (q[1] !== 8'h22) $display("FAIL good_b1 got %0h want 22", q[1]); else pass_cnt++;
      total++; if (q[2] !== 8'h33) $display("FAIL good_b2 got %0h want 33", q[2]); else pass_cnt++;
    end
  endtask

  task automatic test_bad_csum;
    int ok0, err0;
    out_ready = 1'b0; q.delete(); ok0 = ok_cnt; err0 = err_cnt;
    send_byte(8'hA5);
    send_byte(8'h02);
    // First payload byte: visible exactly one cycle after its strobe.
    @(posedge CLOCK_50); #1;
    rx_data = 8'h01; rx_done = 1'b1;
    repeat (3) @(posedge CLOCK_50); #1;
    total++; if (out_valid !== 1'b0) $display("FAIL lat_early got %0b want 0", out_valid); else pass_cnt++;
    @(posedge CLOCK_50); #1;
    total++; if (out_valid !== 1'b1) $display("FAIL lat_valid got %0b want 1", out_valid); else pass_cnt++;
    total++; if (out_data !== 8'h01) $display("FAIL lat_data got %0h want 01", out_data); else pass_cnt++;
    repeat (2) @(posedge CLOCK_50); #1 rx_done = 1'b0;
    repeat (4) @(posedge CLOCK_50); #1;
    send_byte(8'h02);
    send_byte(8'h00);
    repeat (5) @(posedge CLOCK_50); #1;
    total++; if (err_cnt - err0 !== 1) $display("FAIL csum_err got %0d want 1", err_cnt - err0); else pass_cnt++;
    total++; if (err_code !== 2'd1) $display("FAIL csum_code got %0d want 1", err_code); else pass_cnt++;
    total++; if (ok_cnt - ok0 !== 0) $display("FAIL csum_ok got %0d want 0", ok_cnt - ok0); else pass_cnt++;
    total++; if (fifo_count !== 5'd2) $display("FAIL csum_count got %0d want 2", fifo_count); else pass_cnt++;
    out_ready = 1'b1;
    repeat (5) @(posedge CLOCK_50); #1;
    total++; if (q.size() !== 2) $display("FAIL csum_nbytes got %0d want 2", q.size()); else pass_cnt++;
    if (q.size() == 2) begin
      total++; if (q[0] !== 8'h01 || q[1] !== 8'h02)
        $display("FAIL csum_bytes got %0h %0h want 01 02", q[0], q[1]); else pass_cnt++;
    end
  endtask

  task automatic test_timeout;
    int ok0, err0;
    out_ready = 1'b1; ok0 = ok_cnt; err0 = err_cnt;
    send_byte(8'hA5);
    total++; if (busy !== 1'b1) $display("FAIL tmo_busy_in got %0b want 1", busy); else pass_cnt++;
    send_byte(8'h04);
    send_byte(8'h01);
    repeat (TMO + 40) @(posedge CLOCK_50); #1;
    total++; if (err_cnt - err0 !== 1) $display("FAIL tmo_err got %0d want 1", err_cnt - err0); else pass_cnt++;
    total++; if (err_code !== 2'd2) $display("FAIL tmo_code got %0d want 2", err_code); else pass_cnt++;
    total++; if (busy !== 1'b0) $display("FAIL tmo_busy got %0b want 0", busy); else pass_cnt++;
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h07); send_byte(8'h07);
    repeat (5) @(posedge CLOCK_50); #1;
    total++; if (ok_cnt - ok0 !== 1) $display("FAIL tmo_next_ok got %0d want 1", ok_cnt - ok0); else pass_cnt++;
  endtask

  task automatic test_overflow;
    int ok0, err0;
    out_ready = 1'b0; ok0 = ok_cnt; err0 = err_cnt;
    send_byte(8'hA5);
    send_byte(8'h14);
    for (int i = 1; i <= 20; i++) send_byte(8'(i));
    send_byte(8'hD2);
    repeat (5) @(posedge CLOCK_50); #1;
    total++; if (fifo_count !== 5'd16) $display("FAIL ovf_count got %0d want 16", fifo_count); else pass_cnt++;
    total++; if (err_cnt - err0 !== 1) $display("FAIL ovf_err got %0d want 1", err_cnt - err0); else pass_cnt++;
    total++; if (err_code !== 2'd3) $display("FAIL ovf_code got %0d want 3", err_code); else pass_cnt++;
    total++; if (ok_cnt - ok0 !== 0) $display("FAIL ovf_ok got %0d want 0", ok_cnt - ok0); else pass_cnt++;
    q.delete(); out_ready = 1'b1;
    repeat (25) @(posedge CLOCK_50); #1;
    total++; if (q.size() !== 16) $display("FAIL ovf_nbytes got %0d want 16", q.size()); else pass_cnt++;
    if (q.size() == 16) begin
      total++; if (q[0] !== 8'h01 || q[15] !== 8'h10)
        $display("FAIL ovf_kept got %0h..%0h want 01..10", q[0], q[15]); else pass_cnt++;
    end
  endtask

  task automatic test_full_push_pop;
    int ok0, err0;
    out_ready = 1'b0; q.delete(); ok0 = ok_cnt; err0 = err_cnt;
    send_byte(8'hA5);
    send_byte(8'h11);
    for (int i = 0; i < 16; i++) send_byte(8'h21 + 8'(i));
    total++; if (fifo_count !== 5'd16) $display("FAIL fpp_full got %0d want 16", fifo_count); else pass_cnt++;
    send_byte_pop(8'h31);
    total++; if (fifo_count !== 5'd16) $display("FAIL fpp_count got %0d want 16", fifo_count); else pass_cnt++;
    total++; if (q.size() !== 1) $display("FAIL fpp_pops got %0d want 1", q.size()); else pass_cnt++;
    send_byte(8'hB9);
    repeat (5) @(posedge CLOCK_50); #1;
    total++; if (ok_cnt - ok0 !== 1) $display("FAIL fpp_ok got %0d want 1", ok_cnt - ok0); else pass_cnt++;
    total++; if (err_cnt - err0 !== 0) $display("FAIL fpp_err got %0d want 0", err_cnt - err0); else pass_cnt++;
    total++; if (out_data !== 8'h22) $display("FAIL fpp_head got %0h want 22", out_data); else pass_cnt++;
    out_ready = 1'b1;
    repeat (25) @(posedge CLOCK_50); #1;
    total++; if (q.size() !== 17) $display("FAIL fpp_nbytes got %0d want 17", q.size()); else pass_cnt++;
    if (q.size() == 17) begin
      total++; if (q[0] !== 8'h21 || q[16] !== 8'h31)
        $display("FAIL fpp_order got %0h..%0h want 21..31", q[0], q[16]); else pass_cnt++;
    end
  endtask

  task automatic test_zero_len;
    int ok0, err0;
    logic [7:0] bytes [5];
    bytes = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h00};
    out_ready = 1'b1; ok0 = ok_cnt; err0 = err_cnt;
    for (int i = 0; i < 5; i++) send_byte(bytes[i]);
    repeat (5) @(posedge CLOCK_50); #1;
    total++; if (err_cnt - err0 !== 1) $display("FAIL zl_err got %0d want 1", err_cnt - err0); else pass_cnt++;
    total++; if (err_code !== 2'd0) $display("FAIL zl_code got %0d want 0", err_code); else pass_cnt++;
    total++; if (ok_cnt - ok0 !== 0) $display("FAIL zl_ok got %0d want 0", ok_cnt - ok0); else pass_cnt++;
    total++; if (busy !== 1'b0) $display("FAIL zl_busy got %0b want 0", busy); else pass_cnt++;
  endtask

  task automatic test_reset_midframe;
    int ok0, err0;
    out_ready = 1'b0;
    send_byte(8'hA5); send_byte(8'h05); send_byte(8'h01); send_byte(8'h02);
    total++; if (fifo_count !== 5'd2) $display("FAIL mr_pre_count got %0d want 2", fifo_count); else pass_cnt++;
    total++; if (busy !== 1'b1) $display("FAIL mr_pre_busy got %0b want 1", busy); else pass_cnt++;
    ok0 = ok_cnt; err0 = err_cnt;
    @(posedge CLOCK_50); #1;
    RST_N = 1'b0;
    // Flag already high across reset release must not be taken as a byte.
    rx_data = 8'hA5; rx_done = 1'b1;
    #1;
    total++; if (fifo_count !== 5'd0) $display("FAIL mr_count got %0d want 0", fifo_count); else pass_cnt++;
    total++; if (busy !== 1'b0) $display("FAIL mr_busy got %0b want 0", busy); else pass_cnt++;
    total++; if (out_valid !== 1'b0) $display("FAIL mr_valid got %0b want 0", out_valid); else pass_cnt++;
    repeat (3) @(posedge CLOCK_50); #1;
    RST_N = 1'b1;
    repeat (15) @(posedge CLOCK_50); #1;
    total++; if (busy !== 1'b0) $display("FAIL mr_stuck_flag got busy %0b want 0", busy); else pass_cnt++;
    total++; if (ok_cnt - ok0 !== 0 || err_cnt - err0 !== 0)
      $display("FAIL mr_pulses got ok %0d err %0d want 0 0", ok_cnt - ok0, err_cnt - err0); else pass_cnt++;
    rx_done = 1'b0;
    repeat (5) @(posedge CLOCK_50); #1;
    out_ready = 1'b1; ok0 = ok_cnt;
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h07); send_byte(8'h07);
    repeat (5) @(posedge CLOCK_50); #1;
    total++; if (ok_cnt - ok0 !== 1) $display("FAIL mr_after_ok got %0d want 1", ok_cnt - ok0); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_csum();
    test_timeout();
    test_overflow();
    test_full_push_pop();
    test_zero_len();
    test_reset_midframe();
    total++; if (both_cnt !== 0) $display("FAIL ok_err_overlap got %0d want 0", both_cnt); else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #5ms;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1);
  end

endmodule
